// File: rtl/fixed_point_dot_acc_pkg.sv
// Shared fixed-point definitions for the Q16.15 dot-product datapath.
package fxp_pkg;

   localparam int unsigned FXP_W     = 32;
   localparam int unsigned FXP_F     = 15;
   localparam int unsigned ACC_GUARD = 8;
   localparam int unsigned ACC_W     = FXP_W + ACC_GUARD;

   typedef logic signed [FXP_W-1:0] fxp_t;
   typedef logic signed [ACC_W-1:0] fxp_acc_t;

   typedef enum logic {ACC, HOLD} dot_state_e;

   localparam fxp_t FXP_MAX = 32'sh7FFF_FFFF;
   localparam fxp_t FXP_MIN = 32'sh8000_0000;

   // A guard-banded sum fits Q16.15 only when the guard bits and the sign bit agree.
   function automatic logic acc_ovf(input fxp_acc_t v);
      return (v[ACC_W-1:FXP_W-1] != '0) && (v[ACC_W-1:FXP_W-1] != '1);
   endfunction

endpackage

// File: rtl/fixed_point_dot_acc_if.sv
// Element-pair stream in, dot-product result stream out.
interface fixed_point_dot_acc_if
   import fxp_pkg::*;
#(
   parameter int unsigned LEN_W = 9
);
   logic             in_valid;
   logic             in_ready;
   fxp_t             in_a;
   fxp_t             in_b;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   fxp_t             out_data;
   logic [LEN_W-1:0] out_len;
   logic             out_ovf;
   logic             out_trunc;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_len, out_ovf, out_trunc
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_data, out_len, out_ovf, out_trunc
   );
endinterface

// File: rtl/fixed_point_mult.sv
// Combinational Q16.15 x Q16.15 multiplier; result truncated toward -inf and wrapped to 32 bits.
module fixed_point_mult
   import fxp_pkg::*;
(
   input  fxp_t a,
   input  fxp_t b,
   output fxp_t p
);
   logic [2*FXP_W-1:0] full;

   // Full-width sign extension makes the unsigned low product equal the signed one.
   assign full = {{FXP_W{a[FXP_W-1]}}, a} * {{FXP_W{b[FXP_W-1]}}, b};
   assign p    = fxp_t'(full >> FXP_F);
endmodule

// File: rtl/fixed_point_dot_acc.sv
// Streaming Q16.15 dot-product accumulator.
// Optional saturation of the narrowed result is enabled with `define FXP_DOT_SAT_EN.
module fixed_point_dot_acc
   import fxp_pkg::*;
#(
   parameter int unsigned MAX_LEN = 256,
   parameter int unsigned LEN_W   = 9
)(
   input logic                  clk,
   input logic                  rst,
   fixed_point_dot_acc_if.slave bus
);
   dot_state_e       state_q, state_d;
   fxp_t             prod;
   fxp_t             p_reg;
   logic             p_valid;
   logic             p_last;
   logic             trunc;
   fxp_acc_t         acc;
   logic [LEN_W-1:0] count;
   fxp_t             out_data_q;
   logic [LEN_W-1:0] out_len_q;
   logic             out_ovf_q;
   logic             out_trunc_q;

   logic             accept;
   logic             hit_max;
   logic [LEN_W-1:0] count_n;
   fxp_acc_t         acc_sum;
   logic             ovf_n;
   fxp_t             data_n;

   fixed_point_mult u_mult (
      .a (bus.in_a),
      .b (bus.in_b),
      .p (prod)
   );

   assign bus.in_ready = (state_q == ACC) && !(p_valid && p_last);
   assign accept       = bus.in_valid && bus.in_ready;

   // Beats already taken in = accumulated ones plus the one sitting in stage P.
   assign count_n = count + {{(LEN_W-1){1'b0}}, p_valid};
   assign hit_max = (count_n == LEN_W'(MAX_LEN - 1));

   assign acc_sum = acc + fxp_acc_t'(p_reg);
   assign ovf_n   = acc_ovf(acc_sum);

`ifdef FXP_DOT_SAT_EN
   assign data_n = ovf_n ? (acc_sum[ACC_W-1] ? FXP_MIN : FXP_MAX) : acc_sum[FXP_W-1:0];
`else
   assign data_n = acc_sum[FXP_W-1:0];
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACC;
      else     state_q <= state_d;
   end

   // Next state: enter HOLD as the final product lands, leave once the result is taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACC:     if (p_valid && p_last) state_d = HOLD;
         HOLD:    if (bus.out_ready)     state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // Stage P: capture the product and its end-of-vector marking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_reg   <= '0;
         p_valid <= 1'b0;
         p_last  <= 1'b0;
         trunc   <= 1'b0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            p_reg  <= prod;
            p_last <= bus.in_last || hit_max;
            if (hit_max && !bus.in_last) trunc <= 1'b1;
         end else if (p_valid && p_last) begin
            trunc <= 1'b0;
         end
      end
   end

   // Stage A: accumulate, and on the final product load the result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         count       <= '0;
         out_data_q  <= '0;
         out_len_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_trunc_q <= 1'b0;
      end else if (p_valid) begin
         if (p_last) begin
            acc         <= '0;
            count       <= '0;
            out_data_q  <= data_n;
            out_len_q   <= count + LEN_W'(1);
            out_ovf_q   <= ovf_n;
            out_trunc_q <= trunc;
         end else begin
            acc   <= acc_sum;
            count <= count + LEN_W'(1);
         end
      end
   end

   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_len   = out_len_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_trunc = out_trunc_q;
endmodule

// File: tb/tb_fixed_point_dot_acc.sv
// Scoreboard bench for fixed_point_dot_acc; honours `define FXP_DOT_SAT_EN for overflow results.
module tb_fixed_point_dot_acc;
   localparam int unsigned MAX_LEN = 256;
   localparam int unsigned LEN_W   = 9;

   typedef struct packed {
      logic [31:0]      data;
      logic [LEN_W-1:0] len;
      logic             ovf;
      logic             trunc;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   accept_cyc;
   res_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fixed_point_dot_acc_if #(.LEN_W(LEN_W)) bus ();

   fixed_point_dot_acc #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Present one pair from a negedge, wait for acceptance, return at the following negedge.
   task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b, need 1", bus.in_ready);
      end
      @(posedge clk);
      accept_cyc = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc}
          !== {1'b1, 1'b0, 32'h0, 9'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b vld=%b data=%h len=%0d ovf=%b tr=%b, need 1 0 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, bus.out_ovf,
                  bus.out_trunc);
      end
   endtask

   task automatic test_single();
      res_t e, got;
      exp_q.push_back(res_t'{32'h0003_0000, 9'd1, 1'b0, 1'b0});
      send_beat(32'h0001_0000, 32'h0001_8000, 1'b1);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_n1: vld/rdy=%b, need 00", {bus.out_valid, bus.in_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_n2: vld/rdy=%b, need 10", {bus.out_valid, bus.in_ready});
      end
      if (bus.out_valid && exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL single_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_release: vld/rdy=%b, need 01", {bus.out_valid, bus.in_ready});
      end
   endtask

   task automatic test_back_to_back();
      res_t e, got;
      int   first;
      logic [31:0] av[4] = '{32'h8000, 32'h1_0000, 32'h1_8000, 32'h2_0000};
      exp_q.push_back(res_t'{32'h0005_0000, 9'd4, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) begin
         send_beat(av[i], 32'h8000, i == 3);
         if (i == 0) first = accept_cyc;
      end
      n_checks++;
      if (accept_cyc - first != 3) begin
         n_fail++;
         $display("FAIL b2b_throughput: span %0d cycles, need 3", accept_cyc - first);
      end
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_n1: vld/rdy=%b, need 00", {bus.out_valid, bus.in_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_n2: vld/rdy=%b, need 10", {bus.out_valid, bus.in_ready});
      end
      if (bus.out_valid && exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_release: in_ready=%b, need 1", bus.in_ready);
      end
   endtask

   // Short vectors whose only interest is the value, not the timing.
   task automatic test_values();
      res_t e, got;
      exp_q.push_back(res_t'{32'hFFFE_8000, 9'd1, 1'b0, 1'b0});
      send_beat(32'hFFFF_4000, 32'h0001_0000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL neg_valid: out_valid=%b, need 1", bus.out_valid);
      end else if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL neg_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
`ifdef FXP_DOT_SAT_EN
      exp_q.push_back(res_t'{32'h7FFF_FFFF, 9'd2, 1'b1, 1'b0});
`else
      exp_q.push_back(res_t'{32'h8000_0000, 9'd2, 1'b1, 1'b0});
`endif
      send_beat(32'h4000_0000, 32'h0000_8000, 1'b0);
      send_beat(32'h4000_0000, 32'h0000_8000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_valid: out_valid=%b, need 1", bus.out_valid);
      end else if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL ovf_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_truncation();
      res_t e, got;
      int   first;
      exp_q.push_back(res_t'{32'h0080_0000, 9'(MAX_LEN), 1'b0, 1'b1});
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         send_beat(32'h8000, 32'h8000, 1'b0);
         if (i == 0) first = accept_cyc;
      end
      n_checks++;
      if (accept_cyc - first != int'(MAX_LEN) - 1) begin
         n_fail++;
         $display("FAIL trunc_throughput: span %0d, need %0d", accept_cyc - first, MAX_LEN - 1);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL trunc_stop: in_ready=%b, need 0", bus.in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL trunc_valid: out_valid=%b, need 1", bus.out_valid);
      end else if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL trunc_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
      exp_q.push_back(res_t'{32'h0000_8000, 9'd1, 1'b0, 1'b0});
      send_beat(32'h8000, 32'h8000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL post_trunc_valid: out_valid=%b, need 1", bus.out_valid);
      end else if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL post_trunc_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_stall_reset();
      res_t e, got;
      bus.out_ready = 1'b0;
      exp_q.push_back(res_t'{32'h0002_0000, 9'd1, 1'b0, 1'b0});
      send_beat(32'h0001_0000, 32'h0001_0000, 1'b1);
      @(negedge clk);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      for (int i = 0; i < 5; i++) begin
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if ({bus.out_valid, bus.in_ready} !== 2'b10 || got !== e) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: vld/rdy=%b res=%h, need 10 res=%h", i,
                     {bus.out_valid, bus.in_ready}, got, e);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_release: vld/rdy=%b, need 01", {bus.out_valid, bus.in_ready});
      end
      send_beat(32'h7000_0000, 32'h0001_0000, 1'b0);
      send_beat(32'h7000_0000, 32'h0001_0000, 1'b0);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc}
          !== {1'b1, 1'b0, 32'h0, 9'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midvec_reset: rdy=%b vld=%b data=%h len=%0d, need 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_data, bus.out_len);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(res_t'{32'h0001_8000, 9'd1, 1'b0, 1'b0});
      send_beat(32'h0001_8000, 32'h0000_8000, 1'b1);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_valid: out_valid=%b, need 1", bus.out_valid);
      end else if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {bus.out_data, bus.out_len, bus.out_ovf, bus.out_trunc};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL post_reset_result: got %h, need %h", got, e);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_values();
      test_truncation();
      test_stall_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results outstanding, need 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fixed_point_dot_acc.md
# fixed_point_dot_acc

Streaming dot-product engine for Q16.15 vectors (1 sign + 16 integer + 15 fraction bits, two's complement). It accepts element pairs one per cycle and multiplies each pair with an internal `fixed_point_mult` instance. Products are summed in a guard-banded accumulator, and one 32-bit Q16.15 result is emitted per vector. It sits directly downstream of the multiplier and feeds the matrix-vector and norm stages.

## Interface
- `MAX_LEN`, default 256: maximum elements per vector, at most 2^ACC_GUARD.
- `LEN_W`, default 9: width of the element counter and `out_len`; must satisfy 2^LEN_W > MAX_LEN.
- `clk`  input  1  sole clock; all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state.
- `in_valid`  input  1  element pair present.
- `in_ready`  output  1  block can accept a pair this cycle.
- `in_a`  input  32  Q16.15 element of vector A.
- `in_b`  input  32  Q16.15 element of vector B.
- `in_last`  input  1  marks the final pair of the vector.
- `out_valid`  output  1  result held on `out_data`.
- `out_ready`  input  1  consumer takes the result.
- `out_data`  output  32  Q16.15 dot product.
- `out_len`  output  LEN_W  element count of the reported vector.
- `out_ovf`  output  1  accumulated sum exceeded the Q16.15 range.
- `out_trunc`  output  1  vector was force-terminated at MAX_LEN.

## Operation
- FSM states: ACC (collecting) and HOLD (result presented). Reset state is ACC.
- Beat accept: `in_valid && in_ready`.
- Stage P: on accept, register the `fixed_point_mult(in_a, in_b)` product into `p_reg`, along with `p_valid` and `p_last`.
- `p_last` is set when `in_last` is high, or when the counter shows this beat is the MAX_LEN-th. In the second case `trunc` is latched.
- Stage A: each cycle `p_valid` is high, `acc <= acc + sext(p_reg)`.
  - `acc` is 32+ACC_GUARD bits, ACC_GUARD = 8, so it never wraps internally.
  - Count increments per accumulated beat.
- When the accumulated beat has `p_last`:
  - The output register takes the final value `acc + sext(p_reg)`, narrowed per Configuration.
  - `out_len` = count + 1, `out_ovf` and `out_trunc` are set accordingly.
  - `acc`, count and `trunc` are cleared, and the FSM moves to HOLD.
- `in_ready` = (state == ACC) && !(p_valid && p_last). No beats of the next vector are accepted while the last product is in flight.
- HOLD:
  - `out_valid` = 1 and `in_ready` = 0.
  - On `out_ready`, return to ACC.
  - Outputs remain stable until taken.
- `in_a`, `in_b` and `in_last` are ignored when not accepted.
- Overflow is detected when `acc` bits [39:31] are not all equal.

## Timing
- Reset values: `in_ready` = 1 after reset deasserts; `out_valid` = 0; `out_data` = 0; `out_len` = 0; `out_ovf` = 0; `out_trunc` = 0. Internal `acc`, count, `p_valid` and the FSM state are also cleared.
- Throughput: one pair per cycle within a vector.
- Latency: last pair accepted at edge N means `out_valid` is high from edge N+2.
- Earliest next-vector accept is edge N+3, given `out_ready` high at N+2.
- `in_ready` is low at N+1 and N+2.
- Reset asserted mid-vector or in HOLD: state is discarded immediately with no partial result; the block restarts in ACC.
- A single-element vector (`in_last` on the first beat) is legal: `out_len` = 1.

## Configuration
- `FXP_DOT_SAT_EN` defined:
  - On overflow, `out_data` clamps to 0x7FFF_FFFF for a positive sum or 0x8000_0000 for a negative sum.
  - `out_ovf` = 1.
- Undefined:
  - `out_data` = `acc[31:0]` (wraps).
  - `out_ovf` still reports the overflow.

## Structure
- Shared package `fxp_pkg` holds:
  - `FXP_W` = 32, `FXP_F` = 15, `ACC_GUARD` = 8.
  - typedefs `fxp_t` (logic signed [31:0]) and `fxp_acc_t` (logic signed [39:0]).
  - enum `dot_state_e` {ACC, HOLD}.
  - constants `FXP_MAX` and `FXP_MIN`.
- One sub-module: an existing `fixed_point_mult` instance driving stage P. No other hierarchy.

## Test plan
- Single pair 0x0001_0000 × 0x0001_8000 (2.0 × 3.0) with `in_last` -> `out_data` 0x0003_0000, `out_len` 1, `out_valid` at accept+2.
- Back-to-back A = {1, 2, 3, 4} (0x8000, 0x10000, 0x18000, 0x20000), B = all 0x8000 -> `out_data` 0x0005_0000, `out_len` 4, `in_ready` low exactly two cycles after last.
- Negative: 0xFFFF_4000 × 0x0001_0000 (−1.5 × 2.0) -> 0xFFFE_8000, `out_ovf` 0.
- Overflow: two pairs 0x4000_0000 × 0x0000_8000 -> with macro, 0x7FFF_FFFF and `out_ovf` 1; without macro, 0x8000_0000 and `out_ovf` 1.
- Truncation: MAX_LEN pairs of 0x8000 × 0x8000 with no `in_last` -> result 0x0080_0000, `out_len` MAX_LEN, `out_trunc` 1. The next beat starts a new vector.
- Stall and reset: hold `out_ready` low 5 cycles -> outputs stable and `in_ready` 0. Then assert `rst` mid-vector -> all outputs return to reset values, and the next vector computes correctly.
